acc_veri_tx_ser: RTL and testbench

Parametrised single-clock verification readback serializer for the accelerator result path. It accepts wide result beats from the verification ROM/accumulator side and splits each beat into OUT_W-bit words, least-significant word first. The words are buffered in an internal FIFO and released one word per host read handshake. Input beats are requested with level-based flow control, and `acc_finish` asserts after a programmed number of words has been delivered to the host.

---
 rtl/acc_veri_tx_ser_if.sv | 22 ++
 rtl/acc_veri_tx_ser.sv | 146 ++++++++++++++
 tb/tb_acc_veri_tx_ser.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_veri_tx_ser_if.sv
// Beat-in / word-out handshake bundle between the result source, the host and acc_veri_tx_ser.
interface acc_veri_tx_ser_if #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32
);
  logic [IN_W-1:0]  veri_data_in;
  logic             veri_data_in_vld;
  logic             veri_ins_push;
  logic             rd_req;
  logic [OUT_W-1:0] acc_data;
  logic             acc_data_vld;

  modport master (
    output veri_data_in, veri_data_in_vld, rd_req,
    input  veri_ins_push, acc_data, acc_data_vld
  );

  modport slave (
    input  veri_data_in, veri_data_in_vld, rd_req,
    output veri_ins_push, acc_data, acc_data_vld
  );
endinterface

// File: rtl/acc_veri_tx_ser.sv
// Splits wide result beats into OUT_W words (LSW first), buffers them and hands them out per host read.
// Optional running XOR of delivered words on chk_sum when ACC_VERI_TX_CHKSUM_EN is defined.
module acc_veri_tx_ser #(
  parameter int IN_W        = 128,
  parameter int OUT_W       = 32,
  parameter int FIFO_DEPTH  = 256,
  parameter int PUSH_THRESH = 64,
  parameter int EXP_WORDS   = 1024
) (
  input  logic                        clk_200M,
  input  logic                        rst_n,
  acc_veri_tx_ser_if.slave            bus,
  output logic                        acc_finish,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        ovf_err,
  output logic [OUT_W-1:0]            chk_sum
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CW    = $clog2(EXP_WORDS + 1);
  localparam int SW    = $clog2(RATIO);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SER = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    ser_cnt;
  logic [IN_W-1:0]  shreg;
  logic             push_nxt, load, beat_drop, wr_en, last_word;

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, fifo_full, fifo_empty;
  logic             rd_req_r, rd_req_q, rd_rise, pop;
  logic [CW-1:0]    word_cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CW'(EXP_WORDS)) ? v : v + CW'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    push_nxt  = 1'b0;
    load      = 1'b0;
    beat_drop = 1'b0;
    wr_en     = 1'b0;
    last_word = (ser_cnt == SW'(RATIO - 1));
    case (state)
      IDLE: begin
        beat_drop = bus.veri_data_in_vld;
        if (fifo_level < LW'(PUSH_THRESH)) begin
          state_nxt = REQ;
          push_nxt  = 1'b1;
        end
      end
      REQ: begin
        if (bus.veri_data_in_vld) begin
          load      = 1'b1;
          state_nxt = SER;
        end
      end
      SER: begin
        beat_drop = bus.veri_data_in_vld;
        wr_en     = 1'b1;
        if (last_word) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      ser_cnt           <= '0;
      bus.veri_ins_push <= 1'b0;
    end else begin
      state             <= state_nxt;
      bus.veri_ins_push <= push_nxt;
      if (load)       ser_cnt <= '0;
      else if (wr_en) ser_cnt <= ser_cnt + SW'(1);
    end
  end

  // beat datapath: loaded once per strobe, low word peeled off each SER cycle
  always_ff @(posedge clk_200M) begin
    if (load)       shreg <= bus.veri_data_in;
    else if (wr_en) shreg <= shreg >> OUT_W;
  end

  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_level == '0);
  assign wr_ok      = wr_en & ~fifo_full;
  assign rd_rise    = rd_req_r & ~rd_req_q;
  assign pop        = rd_rise & ~fifo_empty;

  always_ff @(posedge clk_200M) begin
    if (wr_ok) mem[wr_ptr] <= shreg[OUT_W-1:0];
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(wr_ok) - LW'(pop);
      if (beat_drop || (wr_en && fifo_full)) ovf_err <= 1'b1;
    end
  end

  // host side: show-ahead head word is captured on a detected rising edge of rd_req
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      rd_req_r         <= 1'b0;
      rd_req_q         <= 1'b0;
      bus.acc_data     <= '0;
      bus.acc_data_vld <= 1'b0;
      word_cnt         <= '0;
      acc_finish       <= 1'b0;
    end else begin
      rd_req_r <= bus.rd_req;
      rd_req_q <= rd_req_r;
      if (pop) begin
        bus.acc_data     <= mem[rd_ptr];
        bus.acc_data_vld <= 1'b1;
        word_cnt         <= sat_inc(word_cnt);
        if (sat_inc(word_cnt) == CW'(EXP_WORDS)) acc_finish <= 1'b1;
      end else if (!rd_req_r || rd_rise) begin
        bus.acc_data_vld <= 1'b0;
      end
    end
  end

`ifdef ACC_VERI_TX_CHKSUM_EN
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n)   chk_sum <= '0;
    else if (pop) chk_sum <= chk_sum ^ mem[rd_ptr];
  end
`else
  assign chk_sum = '0;
`endif

endmodule

// File: tb/tb_acc_veri_tx_ser.sv
// Bench for acc_veri_tx_ser: random beats against a queue-based word model; honours ACC_VERI_TX_CHKSUM_EN.
module tb_acc_veri_tx_ser;
  localparam int IN_W        = 128;
  localparam int OUT_W       = 32;
  localparam int FIFO_DEPTH  = 256;
  localparam int PUSH_THRESH = 64;
  localparam int EXP_WORDS   = 8;
  localparam int RATIO       = IN_W / OUT_W;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;

  logic             clk_200M = 1'b0;
  logic             rst_n;
  logic             acc_finish, ovf_err;
  logic [LW-1:0]    fifo_level;
  logic [OUT_W-1:0] chk_sum;

  acc_veri_tx_ser_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  acc_veri_tx_ser #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH),
    .PUSH_THRESH(PUSH_THRESH), .EXP_WORDS(EXP_WORDS)
  ) dut (
    .clk_200M  (clk_200M),
    .rst_n     (rst_n),
    .bus       (bus),
    .acc_finish(acc_finish),
    .fifo_level(fifo_level),
    .ovf_err   (ovf_err),
    .chk_sum   (chk_sum)
  );

  always #5 clk_200M = ~clk_200M;

  int tests = 0;
  int fails = 0;
  int push_cnt = 0;
  int beats_sent = 0;

  logic [OUT_W-1:0] mq[$];
  logic [OUT_W-1:0] exp_data, exp_chk;
  logic             exp_vld, exp_ovf;
  int               exp_cnt;

  always @(negedge clk_200M) if (rst_n === 1'b1 && bus.veri_ins_push === 1'b1) push_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_200M);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_data   = '0;
    exp_chk    = '0;
    exp_vld    = 1'b0;
    exp_ovf    = 1'b0;
    exp_cnt    = 0;
    beats_sent = push_cnt;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    model_reset();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_push"},   bus.veri_ins_push, 0);
    check({tag, "_data"},   bus.acc_data, 0);
    check({tag, "_vld"},    bus.acc_data_vld, 0);
    check({tag, "_finish"}, acc_finish, 0);
    check({tag, "_level"},  fifo_level, 0);
    check({tag, "_ovf"},    ovf_err, 0);
    check({tag, "_chk"},    chk_sum, 0);
  endtask

  function automatic logic [IN_W-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_push(input int bound, output bit ok);
    int n = 0;
    while (push_cnt <= beats_sent && n < bound) begin
      tick();
      n++;
    end
    ok = (push_cnt > beats_sent);
  endtask

  task automatic strobe_beat(input logic [IN_W-1:0] beat);
    bus.veri_data_in     = beat;
    bus.veri_data_in_vld = 1'b1;
    tick();
    bus.veri_data_in_vld = 1'b0;
    beats_sent++;
    for (int i = 0; i < RATIO; i++) mq.push_back(beat[i*OUT_W +: OUT_W]);
  endtask

  task automatic send_beat(input logic [IN_W-1:0] beat, input int bound, output bit ok);
    wait_push(bound, ok);
    if (!ok) return;
    strobe_beat(beat);
    repeat (RATIO + 1) tick();
  endtask

  task automatic do_read(input string tag);
    bus.rd_req = 1'b1;
    tick();
    tick();
    if (mq.size() != 0) begin
      exp_data = mq.pop_front();
      exp_vld  = 1'b1;
      if (exp_cnt < EXP_WORDS) exp_cnt++;
      exp_chk  = exp_chk ^ exp_data;
    end else begin
      exp_vld = 1'b0;
    end
    check({tag, "_vld"},    bus.acc_data_vld, exp_vld);
    check({tag, "_data"},   bus.acc_data, exp_data);
    check({tag, "_finish"}, acc_finish, (exp_cnt >= EXP_WORDS));
`ifdef ACC_VERI_TX_CHKSUM_EN
    check({tag, "_chk"},    chk_sum, exp_chk);
`else
    check({tag, "_chk"},    chk_sum, 0);
`endif
    check({tag, "_level"},  fifo_level, mq.size());
    tick();
    check({tag, "_vld_hold"}, bus.acc_data_vld, exp_vld);
    bus.rd_req = 1'b0;
    tick();
    tick();
    check({tag, "_vld_drop"},  bus.acc_data_vld, 0);
    check({tag, "_data_hold"}, bus.acc_data, exp_data);
  endtask

  initial begin
    bit              ok;
    int              base, nbeats;
    logic [IN_W-1:0] beat_a, beat_b;

    rst_n                = 1'b0;
    bus.veri_data_in     = '0;
    bus.veri_data_in_vld = 1'b0;
    bus.rd_req           = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset("rst0");
    rst_n = 1'b1;

    // single fixed beat, one push, four reads in order
    base = push_cnt;
    repeat (20) tick();
    check("push_once", push_cnt - base, 1);
    send_beat(128'h00000004_00000003_00000002_00000001, 60, ok);
    check("push_answered", ok, 1);
    check("basic_level", fifo_level, 4);
    for (int i = 0; i < RATIO; i++) do_read("basic");
    check("basic_last", bus.acc_data, 4);

    // read with nothing buffered
    do_read("empty");
    check("empty_data_kept", bus.acc_data, 4);

    // completion after EXP_WORDS words, then sticky
    apply_reset();
    for (int b = 0; b < 2; b++) begin
      send_beat(rand_beat(), 60, ok);
      check("fin_push", ok, 1);
    end
    check("fin_level", fifo_level, 2 * RATIO);
    for (int i = 0; i < 2 * RATIO; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_read("fin");
    end
    check("fin_set", acc_finish, 1);
    send_beat(rand_beat(), 60, ok);
    check("fin_push2", ok, 1);
    for (int i = 0; i < RATIO; i++) do_read("fin_more");
    check("fin_sticky", acc_finish, 1);

    // fill without reading: requests stop at the threshold
    apply_reset();
    nbeats = 0;
    do begin
      send_beat(rand_beat(), 15, ok);
      if (ok) nbeats++;
    end while (ok && nbeats < 40);
    check("fill_beats", nbeats, (PUSH_THRESH + RATIO - 1) / RATIO);
    check("fill_level", fifo_level, ((PUSH_THRESH + RATIO - 1) / RATIO) * RATIO);
    check("fill_model", fifo_level, mq.size());
    check("fill_ovf", ovf_err, 0);
    do_read("fill_rd");
    do_read("fill_rd");

    // reset in the middle of serialization
    apply_reset();
    wait_push(60, ok);
    check("midrst_push", ok, 1);
    strobe_beat(rand_beat());
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    tick();
    model_reset();
    rst_n = 1'b1;
    send_beat(rand_beat(), 60, ok);
    check("midrst_repush", ok, 1);
    check("midrst_level", fifo_level, RATIO);
    for (int i = 0; i < RATIO; i++) do_read("midrst_rd");

    // strobe during serialization is dropped
    wait_push(60, ok);
    check("ovf_push", ok, 1);
    beat_a = rand_beat();
    beat_b = rand_beat();
    strobe_beat(beat_a);
    bus.veri_data_in     = beat_b;
    bus.veri_data_in_vld = 1'b1;
    tick();
    bus.veri_data_in_vld = 1'b0;
    exp_ovf = 1'b1;
    repeat (RATIO) tick();
    check("ovf_flag", ovf_err, exp_ovf);
    check("ovf_level", fifo_level, RATIO);
    for (int i = 0; i < RATIO; i++) do_read("ovf_rd");
    check("ovf_sticky", ovf_err, exp_ovf);
    check("ovf_finish", acc_finish, (exp_cnt >= EXP_WORDS));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
